collision_game_ctrl: RTL and testbench

COLLISION_GAME_CTRL -- requirements
Module: collision_game_ctrl

---
 rtl/game_pkg.sv | 19 +
 rtl/pixel_overlap_det.sv | 58 +++++
 rtl/collision_game_ctrl.sv | 118 +++++++++++
 tb/tb_collision_game_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings, pixel constants and helpers for the collision game
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_CRASH = 2'b10,
        ST_OVER  = 2'b11
    } game_state_e;

    localparam logic [11:0] BLACK     = 12'h000;
    localparam logic [9:0]  H_VISIBLE = 10'd640;
    localparam logic [9:0]  V_VISIBLE = 10'd480;

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

endpackage

// File: rtl/pixel_overlap_det.sv
// rtl/pixel_overlap_det.sv - registers the pixel stage and keeps a per-frame sticky overlap flag
module pixel_overlap_det
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic        video_on,
    input  logic [11:0] layer_a,
    input  logic [11:0] layer_b,
    input  logic        arm,
    input  logic        clr,
    output logic        sof,
    output logic        hit,
    output logic        hit_pending
);

    logic [9:0]  row_q;
    logic [9:0]  col_q;
    logic        von_q;
    logic [11:0] a_q;
    logic [11:0] b_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
            von_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            row_q <= pix_row;
            col_q <= pix_col;
            von_q <= video_on;
            a_q   <= layer_a;
            b_q   <= layer_b;
        end
    end

    assign sof = (row_q == 10'd0) && (col_q == 10'd0);
    assign hit = von_q && (row_q < V_VISIBLE) && (col_q < H_VISIBLE)
                 && (a_q != BLACK) && (b_q != BLACK);

    // At sof the old frame's verdict is consumed; a hit on the sof pixel seeds the new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_pending <= 1'b0;
        end else if (clr) begin
            hit_pending <= 1'b0;
        end else if (sof) begin
            hit_pending <= hit && arm;
        end else if (hit && arm) begin
            hit_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/collision_game_ctrl.sv
// rtl/collision_game_ctrl.sv - game FSM: lives, crash hold-off, game-over and high score tracking
module collision_game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic        video_on,
    input  logic [11:0] moving_cars_out,
    input  logic [11:0] player_car_out,
    input  logic [5:0]  score_in,
    input  logic        btn_start,
    output logic [1:0]  game_state,
    output logic        freeze,
    output logic [1:0]  lives,
    output logic [5:0]  high_score,
    output logic        crash_pulse
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_FRAMES);

    game_state_e state, state_nxt;
    logic [1:0]  lives_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [5:0]  hs_nxt;
    logic        armed, armed_nxt;
    logic        crash_nxt;
    logic        clr_pend;
    logic        sof, hit, hit_pending;

    pixel_overlap_det u_det (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .video_on    (video_on),
        .layer_a     (moving_cars_out),
        .layer_b     (player_car_out),
        .arm         (state == ST_PLAY),
        .clr         (clr_pend),
        .sof         (sof),
        .hit         (hit),
        .hit_pending (hit_pending)
    );

    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        hold_nxt  = hold_cnt;
        hs_nxt    = high_score;
        armed_nxt = armed;
        crash_nxt = 1'b0;
        clr_pend  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (btn_start) begin
                    state_nxt = ST_PLAY;
                    lives_nxt = LIVES_INIT;
                    clr_pend  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (sof && hit_pending) begin
                    crash_nxt = 1'b1;
                    lives_nxt = sat_dec2(lives);
                    if (lives_nxt == 2'd0) begin
                        state_nxt = ST_OVER;
                        armed_nxt = 1'b0;
                        if (score_in > high_score) hs_nxt = score_in;
                    end else begin
                        state_nxt = ST_CRASH;
                        hold_nxt  = HOLD_INIT;
                    end
                end
            end
            ST_CRASH: begin
                if (sof) begin
                    hold_nxt = (hold_cnt == 8'd0) ? 8'd0 : hold_cnt - 8'd1;
                    if (hold_cnt <= 8'd1) state_nxt = ST_PLAY;
                end
            end
            ST_OVER: begin
                // A held button must be released once before it can restart the game.
                if (!btn_start)  armed_nxt = 1'b1;
                else if (armed)  state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            freeze      <= 1'b1;
            lives       <= 2'd0;
            hold_cnt    <= 8'd0;
            high_score  <= 6'd0;
            armed       <= 1'b0;
            crash_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            freeze      <= (state_nxt != ST_PLAY);
            lives       <= lives_nxt;
            hold_cnt    <= hold_nxt;
            high_score  <= hs_nxt;
            armed       <= armed_nxt;
            crash_pulse <= crash_nxt;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_collision_game_ctrl.sv
// tb/tb_collision_game_ctrl.sv - scoreboard bench for collision_game_ctrl using short synthetic frames
module tb_collision_game_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pix_row, pix_col;
    logic        video_on;
    logic [11:0] moving_cars_out, player_car_out;
    logic [5:0]  score_in;
    logic        btn_start;
    logic [1:0]  game_state;
    logic        freeze;
    logic [1:0]  lives;
    logic [5:0]  high_score;
    logic        crash_pulse;

    typedef struct {
        int lives;
        int state;
    } crash_exp_t;

    crash_exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    collision_game_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pix_row         (pix_row),
        .pix_col         (pix_col),
        .video_on        (video_on),
        .moving_cars_out (moving_cars_out),
        .player_car_out  (player_car_out),
        .score_in        (score_in),
        .btn_start       (btn_start),
        .game_state      (game_state),
        .freeze          (freeze),
        .lives           (lives),
        .high_score      (high_score),
        .crash_pulse     (crash_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && crash_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_crash", 1, 0);
            end else begin
                crash_exp_t e;
                e = exp_q.pop_front();
                chk("crash_lives", int'(lives), e.lives);
                chk("crash_state", int'(game_state), e.state);
            end
        end
    end

    task automatic pix(input int r, input int c, input logic von, input logic overlap);
        pix_row         = 10'(r);
        pix_col         = 10'(c);
        video_on        = von;
        moving_cars_out = overlap ? 12'hF00 : 12'h000;
        player_car_out  = overlap ? 12'hF00 : 12'h0F0;
        @(negedge clk);
    endtask

    // One short frame: sof pixel, filler, the (200,300) probe pixel, filler.
    task automatic frame(input logic overlap, input logic von);
        pix(0, 0, 1'b1, 1'b0);
        pix(0, 1, 1'b1, 1'b0);
        pix(200, 300, von, overlap);
        pix(1, 0, 1'b1, 1'b0);
    endtask

    // Overlap one frame, let the next sof take the crash, and measure the hold-off.
    task automatic crash(input int exp_lives, input int exp_state, input logic hit_in_hold);
        crash_exp_t e;
        int n;
        e.lives = exp_lives;
        e.state = exp_state;
        exp_q.push_back(e);
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b1);
        chk("post_crash_state", int'(game_state), exp_state);
        chk("post_crash_freeze", int'(freeze), 1);
        if (exp_state == 2) begin
            n = 0;
            while (game_state == 2'b10 && n < 130) begin
                n++;
                frame(hit_in_hold && n < 120, 1'b1);
            end
            chk("hold_sof_count", n, 120);
            chk("resume_freeze", int'(freeze), 0);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        btn_start = 1'b0;
        score_in  = 6'd0;
        pix(5, 5, 1'b0, 1'b0);
        pix(5, 6, 1'b0, 1'b0);
        chk("rst_state", int'(game_state), 0);
        chk("rst_freeze", int'(freeze), 1);
        chk("rst_lives", int'(lives), 0);
        chk("rst_hs", int'(high_score), 0);
        chk("rst_crash", int'(crash_pulse), 0);

        reset_n   = 1'b1;
        btn_start = 1'b1;
        pix(5, 7, 1'b1, 1'b0);
        pix(5, 8, 1'b1, 1'b0);
        chk("start_state", int'(game_state), 1);
        chk("start_lives", int'(lives), 3);
        chk("start_freeze", int'(freeze), 0);
        btn_start = 1'b0;

        frame(1'b0, 1'b1);
        frame(1'b0, 1'b1);
        chk("no_hit_lives", int'(lives), 3);

        crash(2, 2, 1'b1);
        chk("after_hold_lives", int'(lives), 2);

        frame(1'b1, 1'b0);
        frame(1'b0, 1'b1);
        chk("von_off_lives", int'(lives), 2);
        chk("von_off_state", int'(game_state), 1);

        score_in = 6'd17;
        crash(1, 2, 1'b0);
        btn_start = 1'b1;
        crash(0, 3, 1'b0);
        chk("over_hs17", int'(high_score), 17);
        chk("over_lives", int'(lives), 0);

        repeat (10) pix(3, 3, 1'b1, 1'b0);
        chk("over_held_btn", int'(game_state), 3);
        btn_start = 1'b0;
        pix(3, 3, 1'b1, 1'b0);
        btn_start = 1'b1;
        pix(3, 3, 1'b1, 1'b0);
        chk("over_to_idle", int'(game_state), 0);
        pix(3, 3, 1'b1, 1'b0);
        chk("game2_state", int'(game_state), 1);
        chk("game2_lives", int'(lives), 3);

        score_in = 6'd12;
        crash(2, 2, 1'b0);
        crash(1, 2, 1'b0);
        btn_start = 1'b0;
        crash(0, 3, 1'b0);
        chk("over_hs_kept", int'(high_score), 17);

        btn_start = 1'b1;
        pix(3, 3, 1'b1, 1'b0);
        pix(3, 3, 1'b1, 1'b0);
        chk("game3_state", int'(game_state), 1);
        btn_start = 1'b0;
        begin
            crash_exp_t e;
            e.lives = 2;
            e.state = 2;
            exp_q.push_back(e);
        end
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b1);
        repeat (70) frame(1'b0, 1'b1);
        chk("mid_crash_state", int'(game_state), 2);

        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_state", int'(game_state), 0);
        chk("async_rst_lives", int'(lives), 0);
        chk("async_rst_hs", int'(high_score), 0);
        chk("async_rst_freeze", int'(freeze), 1);
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
